// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and a shift-add multiplier.
// One operation in flight; results and flags hold in DONE until the consumer accepts.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic [2:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             cry,
  output logic             ovf
);

  if (WIDTH < 4 || WIDTH > 64) begin : g_width_chk
    $error("alu_seq: WIDTH must be within 4..64");
  end

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_MAX  = 3'b010;
  localparam logic [2:0] OP_HADD = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zer_q, zer_d;
  logic             neg_q, neg_d;
  logic             cry_q, cry_d;
  logic             ovf_q, ovf_d;

  // Shared adder: add, increment and halved-add differ only in B and carry-in.
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   add_s;
  logic             add_v;

  always_comb begin
    add_b = inB;
    add_c = 1'b0;
    unique case (opc)
      OP_ADD:  add_c = inC;
      OP_INC:  add_b = WIDTH'(1);
      OP_HADD: add_b = {inB[WIDTH-1], inB[WIDTH-1:1]};
      default: add_b = inB;
    endcase
  end

  assign add_s = {1'b0, inA} + {1'b0, add_b}
               + {{WIDTH{1'b0}}, add_c};
  assign add_v = (inA[WIDTH-1] == add_b[WIDTH-1])
              && (add_s[WIDTH-1] != inA[WIDTH-1]);

  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (opc)
      OP_ADD, OP_INC, OP_HADD: begin
        alu_r = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_v = add_v;
      end
      OP_MAX: begin
        alu_r = ($signed(inA) >= $signed(inB)) ? inA : inB;
      end
      OP_AND:  alu_r = inA & inB;
      OP_OR:   alu_r = inA | inB;
      OP_NOT:  alu_r = ~inA;
      default: alu_r = '0;
    endcase
  end

  // One shift-add step per BUSY cycle; the multiplicand is shifted by cnt.
  logic [W2-1:0] partial;
  logic [W2-1:0] mul_sum;

  assign partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  assign mul_sum = mplier_q[0] ? (acc_q + partial) : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zer_d    = zer_q;
    neg_d    = neg_q;
    cry_d    = cry_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (opc == OP_MUL) begin
            mcand_d  = inA;
            mplier_d = inB;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            res_d   = alu_r;
            zer_d   = (alu_r == '0);
            neg_d   = alu_r[WIDTH-1];
            cry_d   = alu_c;
            ovf_d   = alu_v;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        acc_d    = mul_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = mul_sum[WIDTH-1:0];
          zer_d   = (mul_sum[WIDTH-1:0] == '0);
          neg_d   = mul_sum[WIDTH-1];
          cry_d   = |mul_sum[W2-1:WIDTH];
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      zer_q    <= 1'b0;
      neg_q    <= 1'b0;
      cry_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      zer_q    <= zer_d;
      neg_q    <= neg_d;
      cry_q    <= cry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign outW      = res_q;
  assign zer       = zer_q;
  assign neg       = neg_q;
  assign cry       = cry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=16 and WIDTH=8.
// Expected values are hand-computed; flags are compared as {zer,neg,cry,ovf}.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        iv = 1'b0;
  logic        ir;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c = 1'b0;
  logic [2:0]  op = '0;
  logic        ov;
  logic        ordy = 1'b0;
  logic [15:0] w;
  logic        z, n, cy, v;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        c8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic        ov8;
  logic        ordy8 = 1'b0;
  logic [7:0]  w8;
  logic        z8, n8, cy8, v8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .inA(a), .inB(b), .inC(c), .opc(op),
    .out_valid(ov), .out_ready(ordy),
    .outW(w), .zer(z), .neg(n), .cry(cy), .ovf(v)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .inA(a8), .inB(b8), .inC(c8), .opc(op8),
    .out_valid(ov8), .out_ready(ordy8),
    .outW(w8), .zer(z8), .neg(n8), .cry(cy8), .ovf(v8)
  );

  // Called #1 after a rising edge with dut16 idle; returns edges to out_valid.
  task automatic issue16(input logic [2:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic cc,
                         output int lat);
    iv = 1'b1; op = o; a = aa; b = bb; c = cc;
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 1;
    while (!ov && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain16;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, output int lat);
    iv8 = 1'b1; op8 = o; a8 = aa; b8 = bb; c8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain8;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    total++;
    if ({ir, ov, w, z, n, cy, v} !== {1'b1, 1'b0, 16'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset16_async: got ir=%b ov=%b w=%h f=%b%b%b%b want 1 0 0000 0000",
               ir, ov, w, z, n, cy, v);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ir8, ov8, w8, z8, n8, cy8, v8} !== {1'b1, 1'b0, 8'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset8: got ir=%b ov=%b w=%h f=%b%b%b%b want 1 0 00 0000",
               ir8, ov8, w8, z8, n8, cy8, v8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    issue16(3'b000, 16'h7FFF, 16'h0001, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h8000, 4'b0101}) begin
      bad++;
      $display("FAIL add_ovf: got w=%h f=%b%b%b%b want 8000 0101", w, z, n, cy, v);
    end
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL add_latency: got %0d want 1", lat);
    end
    drain16();
    issue16(3'b000, 16'hFFFF, 16'h0001, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0000, 4'b1010}) begin
      bad++;
      $display("FAIL add_carry: got w=%h f=%b%b%b%b want 0000 1010", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b000, 16'hFFFF, 16'h0001, 1'b1, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0001, 4'b0010}) begin
      bad++;
      $display("FAIL add_cin: got w=%h f=%b%b%b%b want 0001 0010", w, z, n, cy, v);
    end
    drain16();
  endtask

  task automatic test_inc;
    int lat;
    issue16(3'b001, 16'h7FFF, 16'h1234, 1'b1, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h8000, 4'b0101}) begin
      bad++;
      $display("FAIL inc_ovf: got w=%h f=%b%b%b%b want 8000 0101", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b001, 16'hFFFF, 16'h0000, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0000, 4'b1010}) begin
      bad++;
      $display("FAIL inc_wrap: got w=%h f=%b%b%b%b want 0000 1010", w, z, n, cy, v);
    end
    drain16();
  endtask

  task automatic test_max;
    int lat;
    issue16(3'b010, 16'hFFFE, 16'h0003, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0003, 4'b0000}) begin
      bad++;
      $display("FAIL max_neg_pos: got w=%h f=%b%b%b%b want 0003 0000", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b010, 16'h0005, 16'hFFFF, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0005, 4'b0000}) begin
      bad++;
      $display("FAIL max_pos_neg: got w=%h f=%b%b%b%b want 0005 0000", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b010, 16'h8000, 16'h8000, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h8000, 4'b0100}) begin
      bad++;
      $display("FAIL max_tie: got w=%h f=%b%b%b%b want 8000 0100", w, z, n, cy, v);
    end
    drain16();
  endtask

  task automatic test_hadd;
    int lat;
    issue16(3'b011, 16'h0010, 16'hFFF0, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0008, 4'b0010}) begin
      bad++;
      $display("FAIL hadd_neg_b: got w=%h f=%b%b%b%b want 0008 0010", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b011, 16'h7FFF, 16'h0002, 1'b1, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h8000, 4'b0101}) begin
      bad++;
      $display("FAIL hadd_ovf: got w=%h f=%b%b%b%b want 8000 0101", w, z, n, cy, v);
    end
    drain16();
  endtask

  task automatic test_logic;
    int lat;
    issue16(3'b100, 16'hF0F0, 16'hFF00, 1'b1, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'hF000, 4'b0100}) begin
      bad++;
      $display("FAIL and: got w=%h f=%b%b%b%b want F000 0100", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b101, 16'h00F0, 16'h0F00, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0FF0, 4'b0000}) begin
      bad++;
      $display("FAIL or: got w=%h f=%b%b%b%b want 0FF0 0000", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b110, 16'h0000, 16'h5555, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'hFFFF, 4'b0100}) begin
      bad++;
      $display("FAIL not: got w=%h f=%b%b%b%b want FFFF 0100", w, z, n, cy, v);
    end
    drain16();
  endtask

  task automatic test_mul;
    int lat;
    bit rdy_seen;
    iv = 1'b1; op = 3'b111; a = 16'h0100; b = 16'h0100; c = 1'b0;
    @(posedge clk); #1;
    op = 3'b000; a = 16'hFFFF;
    lat = 1;
    rdy_seen = 1'b0;
    while (!ov && lat < 200) begin
      if (ir) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    iv = 1'b0;
    total++;
    if ({w, z, n, cy, v} !== {16'h0000, 4'b1010}) begin
      bad++;
      $display("FAIL mul_hi: got w=%h f=%b%b%b%b want 0000 1010", w, z, n, cy, v);
    end
    total++;
    if (lat != 17) begin
      bad++;
      $display("FAIL mul_latency: got %0d want 17", lat);
    end
    total++;
    if (rdy_seen !== 1'b0) begin
      bad++;
      $display("FAIL mul_busy_ready: got in_ready=1 while busy want 0");
    end
    drain16();
    issue16(3'b111, 16'h0012, 16'h0034, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h03A8, 4'b0000}) begin
      bad++;
      $display("FAIL mul_small: got w=%h f=%b%b%b%b want 03A8 0000", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b111, 16'hFFFF, 16'hFFFF, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v} !== {16'h0001, 4'b0010}) begin
      bad++;
      $display("FAIL mul_max: got w=%h f=%b%b%b%b want 0001 0010", w, z, n, cy, v);
    end
    drain16();
    issue16(3'b111, 16'h0000, 16'h1234, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v, lat} !== {16'h0000, 4'b1000, 32'd17}) begin
      bad++;
      $display("FAIL mul_zero: got w=%h f=%b%b%b%b lat=%0d want 0000 1000 lat=17",
               w, z, n, cy, v, lat);
    end
    drain16();
  endtask

  task automatic test_backpressure;
    int lat;
    issue16(3'b000, 16'h7FFF, 16'h0001, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      iv = k[0];
      a = 16'($urandom);
      op = 3'b100;
      @(posedge clk); #1;
      total++;
      if ({w, z, n, cy, v, ir, ov} !== {16'h8000, 4'b0101, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL hold_%0d: got w=%h f=%b%b%b%b ir=%b ov=%b want 8000 0101 0 1",
                 k, w, z, n, cy, v, ir, ov);
      end
    end
    iv = 1'b0;
    drain16();
    total++;
    if ({ir, ov} !== 2'b10) begin
      bad++;
      $display("FAIL release: got ir=%b ov=%b want 1 0", ir, ov);
    end
  endtask

  task automatic test_back_to_back;
    ordy = 1'b1;
    iv = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0002; c = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ov, w} !== {1'b1, 16'h0003}) begin
      bad++;
      $display("FAIL b2b_first: got ov=%b w=%h want 1 0003", ov, w);
    end
    a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    total++;
    if ({ov, ir} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_gap: got ov=%b ir=%b want 0 1", ov, ir);
    end
    @(posedge clk); #1;
    total++;
    if ({ov, w} !== {1'b1, 16'h000A}) begin
      bad++;
      $display("FAIL b2b_second: got ov=%b w=%h want 1 000A", ov, w);
    end
    iv = 1'b0;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_rst_busy;
    int lat;
    issue16(3'b001, 16'h7FFF, 16'h0000, 1'b0, lat);
    drain16();
    iv = 1'b1; op = 3'b111; a = 16'h1234; b = 16'h0002;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++;
    if ({ir, ov} !== 2'b00) begin
      bad++;
      $display("FAIL busy_state: got ir=%b ov=%b want 0 0", ir, ov);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({ir, ov, w, z, n, cy, v} !== {1'b1, 1'b0, 16'h0, 4'b0000}) begin
      bad++;
      $display("FAIL rst_mid_busy: got ir=%b ov=%b w=%h f=%b%b%b%b want 1 0 0000 0000",
               ir, ov, w, z, n, cy, v);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue16(3'b111, 16'h0003, 16'h0005, 1'b0, lat);
    total++;
    if ({w, z, n, cy, v, lat} !== {16'h000F, 4'b0000, 32'd17}) begin
      bad++;
      $display("FAIL after_rst_mul: got w=%h f=%b%b%b%b lat=%0d want 000F 0000 lat=17",
               w, z, n, cy, v, lat);
    end
    drain16();
  endtask

  task automatic test_width8;
    int lat;
    issue8(3'b000, 8'h7F, 8'h01, lat);
    total++;
    if ({w8, z8, n8, cy8, v8, lat} !== {8'h80, 4'b0101, 32'd1}) begin
      bad++;
      $display("FAIL w8_add: got w=%h f=%b%b%b%b lat=%0d want 80 0101 lat=1",
               w8, z8, n8, cy8, v8, lat);
    end
    drain8();
    issue8(3'b111, 8'h10, 8'h10, lat);
    total++;
    if ({w8, z8, n8, cy8, v8} !== {8'h00, 4'b1010}) begin
      bad++;
      $display("FAIL w8_mul: got w=%h f=%b%b%b%b want 00 1010", w8, z8, n8, cy8, v8);
    end
    total++;
    if (lat != 9) begin
      bad++;
      $display("FAIL w8_mul_latency: got %0d want 9", lat);
    end
    drain8();
  endtask

  initial begin
    test_reset();
    test_add();
    test_inc();
    test_max();
    test_hadd();
    test_logic();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_rst_busy();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
